// File: rtl/hdmi_period_scheduler.sv
// hdmi_period_scheduler
//   Video timing generator and period sequencer for one HDMI link. Walks a
//   raster of H_TOTAL x V_TOTAL character clocks. For every position it drives
//   the shared mode/ctrl inputs of the three TMDS channel encoders: control,
//   video preamble/guard/active, and data-island preamble/guard/data. It also
//   requests pixel data from the video source. At most one data island is
//   scheduled per line, and only when the packet builder asks for it.
//
// Ports
//   clk          pixel / TMDS character clock
//   rst          asynchronous active-high reset
//   island_req   packet builder has ISLAND_PACKETS packets ready
//   island_ack   one-cycle pulse: island accepted, preamble starts next cycle
//   island_rd    high on every island data cycle
//   island_pkt   packet index within the island
//   island_word  word index 0..31 within the packet
//   de           active video
//   pix_x/pix_y  pixel column/row, valid when de
//   hsync/vsync  syncs, active level SYNC_POL
//   frame_start  pulse at h=0, v=0
//   mode         0 control, 1 video, 2 video guard, 3 island, 4 island guard
//   ctrl0        channel 0 ctrl = {vsync,hsync}
//   ctrl1        channel 1 ctrl {CTL1,CTL0}
//   ctrl2        channel 2 ctrl {CTL3,CTL2}
//
// Every output is registered. The outputs for counter position (h,v) appear
// one cycle after the counters hold that position.
//
//   state       | meaning
//   ------------+---------------------------------------------------
//   CTRL        | control period, CTL bits idle
//   VID_PRE     | 8-cycle video preamble (CTL0=1)
//   VID_GUARD   | 2-cycle video leading guard band
//   VIDEO       | active pixels
//   ISL_PRE     | 8-cycle data-island preamble (CTL0=1, CTL2=1)
//   ISL_GUARD_L | 2-cycle island leading guard band
//   ISLAND      | 32*ISLAND_PACKETS island data cycles
//   ISL_GUARD_T | 2-cycle island trailing guard band

module hdmi_period_scheduler #(
    parameter int H_ACTIVE       = 640,
    parameter int H_FP           = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BP           = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FP           = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BP           = 33,
    parameter int SYNC_POL       = 0,
    parameter int ISLAND_PACKETS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        island_req,
    output logic        island_ack,
    output logic        island_rd,
    output logic [4:0]  island_pkt,
    output logic [4:0]  island_word,
    output logic        de,
    output logic [11:0] pix_x,
    output logic [10:0] pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic [2:0]  mode,
    output logic [1:0]  ctrl0,
    output logic [1:0]  ctrl1,
    output logic [1:0]  ctrl2
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // The island must fit between the end of the front porch and the video
    // preamble, and must leave at least 4 control cycles before the preamble.
    if (H_SYNC + H_BP < 12 + 32 * ISLAND_PACKETS + 10 + 4) begin : g_bad_island_fit
        $fatal(1, "hdmi_period_scheduler: island does not fit in horizontal blanking");
    end
    if (ISLAND_PACKETS < 1 || ISLAND_PACKETS > 18) begin : g_bad_island_packets
        $fatal(1, "hdmi_period_scheduler: ISLAND_PACKETS must be 1..18");
    end

    localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT     = 12'(H_ACTIVE);
    localparam logic [10:0] V_ACT     = 11'(V_ACTIVE);
    localparam logic [10:0] V_ACT_M1  = 11'(V_ACTIVE - 1);
    localparam logic [11:0] VPRE_S    = 12'(H_TOTAL - 10);
    localparam logic [11:0] VGRD_S    = 12'(H_TOTAL - 2);
    localparam logic [11:0] ISL_DEC   = 12'(H_ACTIVE + H_FP - 1);
    localparam logic [11:0] ISL_PRE_S = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] ISL_GL_S  = 12'(H_ACTIVE + H_FP + 8);
    localparam logic [11:0] ISL_DAT_S = 12'(H_ACTIVE + H_FP + 10);
    localparam logic [11:0] ISL_GT_S  = 12'(H_ACTIVE + H_FP + 10 + 32 * ISLAND_PACKETS);
    localparam logic [11:0] ISL_END   = 12'(H_ACTIVE + H_FP + 12 + 32 * ISLAND_PACKETS);
    localparam logic [11:0] HS_S      = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_E      = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_S      = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_E      = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        SYNC_ACT  = (SYNC_POL != 0);

    typedef enum logic [2:0] {
        ST_CTRL,
        ST_VID_PRE,
        ST_VID_GUARD,
        ST_VIDEO,
        ST_ISL_PRE,
        ST_ISL_GUARD_L,
        ST_ISLAND,
        ST_ISL_GUARD_T
    } state_t;

    state_t      state;
    state_t      nxt_state;
    logic [11:0] h_cnt;
    logic [10:0] v_cnt;
    logic        isl_line;   // island accepted for the current line
    logic        pre_line;
    logic        hs_lvl;
    logic        vs_lvl;
    logic        isl_take;

    // Period for the position the counters hold now; registered below.
    always_comb begin
        nxt_state = ST_CTRL;
        // Preamble/guard run at the end of the line that precedes an active line.
        pre_line  = (v_cnt == V_LAST) || (v_cnt < V_ACT_M1);
        if (h_cnt < H_ACT && v_cnt < V_ACT)
            nxt_state = ST_VIDEO;
        else if (pre_line && h_cnt >= VPRE_S && h_cnt < VGRD_S)
            nxt_state = ST_VID_PRE;
        else if (pre_line && h_cnt >= VGRD_S)
            nxt_state = ST_VID_GUARD;
        else if (isl_line && h_cnt >= ISL_PRE_S && h_cnt < ISL_GL_S)
            nxt_state = ST_ISL_PRE;
        else if (isl_line && h_cnt >= ISL_GL_S && h_cnt < ISL_DAT_S)
            nxt_state = ST_ISL_GUARD_L;
        else if (isl_line && h_cnt >= ISL_DAT_S && h_cnt < ISL_GT_S)
            nxt_state = ST_ISLAND;
        else if (isl_line && h_cnt >= ISL_GT_S && h_cnt < ISL_END)
            nxt_state = ST_ISL_GUARD_T;
    end

    always_comb begin
        hs_lvl   = (h_cnt >= HS_S && h_cnt < HS_E) ? SYNC_ACT : ~SYNC_ACT;
        vs_lvl   = (v_cnt >= VS_S && v_cnt < VS_E) ? SYNC_ACT : ~SYNC_ACT;
        isl_take = (h_cnt == ISL_DEC) && island_req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            isl_line    <= 1'b0;
            state       <= ST_CTRL;
            mode        <= 3'd0;
            ctrl0       <= {~SYNC_ACT, ~SYNC_ACT};
            ctrl1       <= 2'b00;
            ctrl2       <= 2'b00;
            de          <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            hsync       <= ~SYNC_ACT;
            vsync       <= ~SYNC_ACT;
            frame_start <= 1'b0;
            island_ack  <= 1'b0;
            island_rd   <= 1'b0;
            island_word <= '0;
            island_pkt  <= '0;
        end else begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end

            if (h_cnt == H_LAST)
                isl_line <= 1'b0;
            else if (isl_take)
                isl_line <= 1'b1;

            state       <= nxt_state;
            island_ack  <= isl_take;
            frame_start <= (h_cnt == 12'd0) && (v_cnt == 11'd0);
            hsync       <= hs_lvl;
            vsync       <= vs_lvl;
            ctrl0       <= {vs_lvl, hs_lvl};

            de          <= (nxt_state == ST_VIDEO);
            pix_x       <= (nxt_state == ST_VIDEO) ? h_cnt : 12'd0;
            pix_y       <= (nxt_state == ST_VIDEO) ? v_cnt : 11'd0;
            island_rd   <= (nxt_state == ST_ISLAND);

            // Word/packet counters restart on entry to ISLAND and hold 0 elsewhere.
            if (nxt_state == ST_ISLAND && state == ST_ISLAND) begin
                island_word <= island_word + 5'd1;
                if (island_word == 5'd31)
                    island_pkt <= island_pkt + 5'd1;
            end else begin
                island_word <= '0;
                island_pkt  <= '0;
            end

            case (nxt_state)
                ST_VID_PRE:     begin mode <= 3'd0; ctrl1 <= 2'b01; ctrl2 <= 2'b00; end
                ST_VID_GUARD:   begin mode <= 3'd2; ctrl1 <= 2'b00; ctrl2 <= 2'b00; end
                ST_VIDEO:       begin mode <= 3'd1; ctrl1 <= 2'b00; ctrl2 <= 2'b00; end
                ST_ISL_PRE:     begin mode <= 3'd0; ctrl1 <= 2'b01; ctrl2 <= 2'b01; end
                ST_ISL_GUARD_L: begin mode <= 3'd4; ctrl1 <= 2'b00; ctrl2 <= 2'b00; end
                ST_ISLAND:      begin mode <= 3'd3; ctrl1 <= 2'b00; ctrl2 <= 2'b00; end
                ST_ISL_GUARD_T: begin mode <= 3'd4; ctrl1 <= 2'b00; ctrl2 <= 2'b00; end
                default:        begin mode <= 3'd0; ctrl1 <= 2'b00; ctrl2 <= 2'b00; end
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler on a small raster.
// H_BP is 50 (H_TOTAL=78, V_TOTAL=8) so that a one-packet island leaves the
// four control cycles the design demands ahead of the video preamble.
// Expected timing for this raster:
//   video preamble h=68..75, video guard h=76..77 on lines 7,0,1,2
//   active video h=0..15 on lines 0..3
//   island: ack h=19, preamble 20..27, guard 28..29, data 30..61, guard 62..63
//   hsync low h=20..27, vsync low on line 5
module tb_hdmi_period_scheduler;

    logic        clk;
    logic        rst;
    logic        island_req;
    logic        island_ack;
    logic        island_rd;
    logic [4:0]  island_pkt;
    logic [4:0]  island_word;
    logic        de;
    logic [11:0] pix_x;
    logic [10:0] pix_y;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
    logic [2:0]  mode;
    logic [1:0]  ctrl0;
    logic [1:0]  ctrl1;
    logic [1:0]  ctrl2;

    int n_vec;
    int n_err;

    // Bench-side raster position and island flag.
    int mh;
    int mv;
    bit misl;
    int last_h;
    int last_v;
    int fs_seen;

    hdmi_period_scheduler #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(50),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .SYNC_POL(0), .ISLAND_PACKETS(1)
    ) dut (
        .clk(clk), .rst(rst), .island_req(island_req),
        .island_ack(island_ack), .island_rd(island_rd),
        .island_pkt(island_pkt), .island_word(island_word),
        .de(de), .pix_x(pix_x), .pix_y(pix_y),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
        .mode(mode), .ctrl0(ctrl0), .ctrl1(ctrl1), .ctrl2(ctrl2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at h=%0d v=%0d: observed %0h expected %0h", tag, last_h, last_v, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mode"},  32'(mode), 32'd0);
        chk({tag, "_ctrl0"}, 32'(ctrl0), 32'h3);
        chk({tag, "_ctrl1"}, 32'(ctrl1), 32'd0);
        chk({tag, "_ctrl2"}, 32'(ctrl2), 32'd0);
        chk({tag, "_de"},    32'(de), 32'd0);
        chk({tag, "_pix"},   32'({pix_x, pix_y}), 32'd0);
        chk({tag, "_sync"},  32'({hsync, vsync}), 32'h3);
        chk({tag, "_fs"},    32'(frame_start), 32'd0);
        chk({tag, "_ack"},   32'(island_ack), 32'd0);
        chk({tag, "_rd"},    32'(island_rd), 32'd0);
        chk({tag, "_word"},  32'({island_pkt, island_word}), 32'd0);
    endtask

    // One character clock: drive req for the position about to be sampled,
    // then check the registered outputs for that position.
    task automatic cyc(input logic req);
        int e_mode, e_c1, e_c2, e_de, e_rd, e_word, e_ack, e_hs, e_vs, e_fs;
        bit pre;
        @(negedge clk);
        island_req = req;
        @(posedge clk);
        #1;
        last_h = mh;
        last_v = mv;
        if (mh == 19 && req) misl = 1'b1;
        pre    = (mv == 7) || (mv <= 2);
        e_mode = 0; e_c1 = 0; e_c2 = 0; e_de = 0; e_rd = 0; e_word = 0;
        if (mv <= 3 && mh <= 15) begin
            e_mode = 1; e_de = 1;
        end else if (pre && mh >= 68 && mh <= 75) begin
            e_c1 = 1;
        end else if (pre && mh >= 76) begin
            e_mode = 2;
        end else if (misl && mh >= 20 && mh <= 27) begin
            e_c1 = 1; e_c2 = 1;
        end else if (misl && (mh == 28 || mh == 29 || mh == 62 || mh == 63)) begin
            e_mode = 4;
        end else if (misl && mh >= 30 && mh <= 61) begin
            e_mode = 3; e_rd = 1; e_word = mh - 30;
        end
        e_ack = (mh == 19 && req) ? 1 : 0;
        e_hs  = (mh >= 20 && mh <= 27) ? 0 : 1;
        e_vs  = (mv == 5) ? 0 : 1;
        e_fs  = (mh == 0 && mv == 0) ? 1 : 0;
        if (frame_start === 1'b1) fs_seen++;

        chk("mode",  32'(mode), 32'(e_mode));
        chk("ctrl1", 32'(ctrl1), 32'(e_c1));
        chk("ctrl2", 32'(ctrl2), 32'(e_c2));
        chk("de",    32'(de), 32'(e_de));
        if (e_de == 1) begin
            chk("pix_x", 32'(pix_x), 32'(mh));
            chk("pix_y", 32'(pix_y), 32'(mv));
        end
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("ctrl0", 32'(ctrl0), 32'({e_vs[0], e_hs[0]}));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("island_ack",  32'(island_ack), 32'(e_ack));
        chk("island_rd",   32'(island_rd), 32'(e_rd));
        chk("island_word", 32'(island_word), 32'(e_word));
        chk("island_pkt",  32'(island_pkt), 32'd0);

        if (mh == 77) begin
            mh   = 0;
            misl = 1'b0;
            mv   = (mv == 7) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; fs_seen = 0;
        mh = 0; mv = 0; misl = 1'b0; last_h = 0; last_v = 0;
        island_req = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");

        // Release just after an edge so the next sampled edge is position (0,0).
        @(posedge clk);
        #2 rst = 1'b0;

        // Free run, no islands, two frames.
        for (int i = 0; i < 2 * 624; i++) cyc(1'b0);
        chk("frames_seen", 32'(fs_seen), 32'd2);

        // Island requested on every line of a frame.
        for (int i = 0; i < 624; i++) cyc(1'b1);

        // Requests outside the decision cycle are ignored; line 5 gets one island.
        for (int i = 0; i < 624; i++) cyc((mh == 25) || (mh == 19 && mv == 5));

        // Random requests; ctrl0 tracks the syncs every cycle.
        for (int i = 0; i < 624; i++) cyc(1'($urandom_range(0, 1)));

        // Run into the island of line 1 and reset at h=40.
        for (int i = 0; i < 700; i++) begin
            cyc(1'b1);
            if (last_h == 40 && last_v == 1) break;
        end
        chk("reached_mid_island", 32'({island_rd, mode}), 32'({1'b1, 3'd3}));
        #2 rst = 1'b1;
        #1;
        chk_reset("async_reset");
        @(posedge clk);
        #1;
        chk_reset("held_reset");
        @(posedge clk);
        #2 rst = 1'b0;
        mh = 0; mv = 0; misl = 1'b0;
        fs_seen = 0;
        for (int i = 0; i < 200; i++) cyc(i >= 100);
        chk("restart_frame_start", 32'(fs_seen), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
